// File: rtl/bg_cal_seq.sv
`default_nettype none
// ============================================================================
// bg_cal_seq : bandgap trim calibration sequencer (settle, convert, capture, hold)
// Rev 1.0
// ============================================================================
module bg_cal_seq #(
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned PERIOD_CYC  = 4096,
  parameter int unsigned DRIFT_TOL   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       recal_req,
  input  logic       err_clr,
  input  logic       bg_valid,
  input  logic [7:0] bg_coarse,
  input  logic [7:0] bg_fine,
  output logic       bg_pwrup,
  output logic [7:0] trim_coarse,
  output logic [7:0] trim_fine,
  output logic       trim_valid,
  output logic       busy,
  output logic       drift_flag,
  output logic       timeout_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CONVERT = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] PERIOD_LAST  = 16'(PERIOD_CYC - 1);
  localparam logic [15:0] DRIFT_LIM    = 16'(DRIFT_TOL);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        vld_prev_q;
  logic [7:0]  trim_coarse_q, trim_coarse_d;
  logic [7:0]  trim_fine_q, trim_fine_d;
  logic        trim_valid_q, trim_valid_d;
  logic        drift_q, drift_d;
  logic        terr_q, terr_d;

  logic [15:0] cnt_inc;
  logic [15:0] new_code, old_code, code_diff;
  logic        vld_edge;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    trim_coarse_d = trim_coarse_q;
    trim_fine_d   = trim_fine_q;
    trim_valid_d  = trim_valid_q;
    drift_d       = drift_q;

    cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    new_code  = {bg_coarse, bg_fine};
    old_code  = {trim_coarse_q, trim_fine_q};
    code_diff = (new_code >= old_code) ? (new_code - old_code) : (old_code - new_code);
    // Edge reference is sampled every cycle, so a level already high on CONVERT entry is ignored
    vld_edge  = bg_valid & ~vld_prev_q;

    terr_d = (state_q == FAULT) ? 1'b1 : (err_clr ? 1'b0 : terr_q);

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SETTLE;
          cnt_d   = 16'd0;
        end
      end
      SETTLE: begin
        if (cnt_q >= SETTLE_LAST) begin
          state_d = CONVERT;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      CONVERT: begin
        if (vld_edge) begin
          state_d       = CAPTURE;
          trim_coarse_d = bg_coarse;
          trim_fine_d   = bg_fine;
          trim_valid_d  = 1'b1;
          drift_d       = trim_valid_q && (code_diff > DRIFT_LIM);
        end else if (cnt_q >= TIMEOUT_LAST) begin
          state_d = FAULT;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      CAPTURE: begin
        state_d = HOLD;
        cnt_d   = 16'd0;
      end
      HOLD: begin
        if (recal_req || (cnt_q >= PERIOD_LAST)) begin
          state_d = SETTLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      FAULT: begin
        state_d = HOLD;
        cnt_d   = 16'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase

    // Disable overrides everything, including a capture landing in the same cycle
    if (!en) begin
      state_d       = IDLE;
      cnt_d         = 16'd0;
      trim_coarse_d = trim_coarse_q;
      trim_fine_d   = trim_fine_q;
      trim_valid_d  = 1'b0;
      drift_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 16'd0;
      vld_prev_q    <= 1'b0;
      trim_coarse_q <= 8'h80;
      trim_fine_q   <= 8'h00;
      trim_valid_q  <= 1'b0;
      drift_q       <= 1'b0;
      terr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      vld_prev_q    <= bg_valid;
      trim_coarse_q <= trim_coarse_d;
      trim_fine_q   <= trim_fine_d;
      trim_valid_q  <= trim_valid_d;
      drift_q       <= drift_d;
      terr_q        <= terr_d;
    end
  end

  assign bg_pwrup    = (state_q == SETTLE) || (state_q == CONVERT);
  assign busy        = (state_q == SETTLE) || (state_q == CONVERT) || (state_q == CAPTURE);
  assign trim_coarse = trim_coarse_q;
  assign trim_fine   = trim_fine_q;
  assign trim_valid  = trim_valid_q;
  assign drift_flag  = drift_q;
  assign timeout_err = terr_q;
  assign state       = state_q;

endmodule
`default_nettype wire
